// File: rtl/dti_pr_tniu_req_afifo_wr.sv
// Purpose : write-side endpoint of the DTI PR request async FIFO (TNIU / far-side clock domain).
// Latency : an accepted beat is in mem and wptr_async advances on the accepting edge; pld_sync is combinational.
// Backpressure: req_ready = !full && !stall && !clear; it releases SYNC_STAGES..SYNC_STAGES+1 cycles after the reader advances.
//
// Ports:
//   clk, rst                 write-domain clock, asynchronous active-high reset
//   req_valid/req_ready      beat handshake; req_payload/srcid/tgtid/qos/last form the beat
//   stall, clear             LP bridge hooks: stall gates req_ready, clear resets pointers synchronously
//   full_zero                registered "every written entry has been consumed"
//   wptr_async               Johnson write pointer, straight from its flop
//   rptr_async               reader Johnson pointer, synchronized here for full/empty
//   rptr_sync                reader Johnson pointer used only as the readout mux select
//   pld_sync                 mem entry addressed by rptr_sync
module dti_pr_tniu_req_afifo_wr #(
  parameter int DATA_WIDTH  = 104,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [89:0]           req_payload,
  input  logic                  req_last,
  input  logic [5:0]            req_srcid,
  input  logic [5:0]            req_tgtid,
  input  logic                  req_qos,
  output logic                  req_ready,
  input  logic                  stall,
  input  logic                  clear,
  output logic                  full_zero,
  output logic [FIFO_DEPTH-1:0] wptr_async,
  input  logic [FIFO_DEPTH-1:0] rptr_async,
  input  logic [FIFO_DEPTH-1:0] rptr_sync,
  output logic [DATA_WIDTH-1:0] pld_sync
);

  localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Entry index of a Johnson code: the count of ones while the MSB is clear,
  // N minus that count once the MSB is set, folded modulo N (all-ones -> 0).
  function automatic logic [IDX_W-1:0] jidx(input logic [FIFO_DEPTH-1:0] p);
    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] v;
    ones = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      ones = ones + CNT_W'(p[i]);
    end
    v = p[FIFO_DEPTH-1] ? (CNT_W'(FIFO_DEPTH) - ones) : ones;
    if (v == CNT_W'(FIFO_DEPTH)) begin
      v = '0;
    end
    return v[IDX_W-1:0];
  endfunction

  // State
  logic [FIFO_DEPTH-1:0]                  wptr_q, wptr_d;
  logic [SYNC_STAGES-1:0][FIFO_DEPTH-1:0] rsync_q, rsync_d;
  logic                                   full_zero_q, full_zero_d;
  logic [DATA_WIDTH-1:0]                  mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]                  mem_d [FIFO_DEPTH];

  // Derived
  logic [FIFO_DEPTH-1:0] rptr_s;
  logic [FIFO_DEPTH-1:0] wptr_nxt;
  logic [DATA_WIDTH-1:0] pld;
  logic                  empty_w;
  logic                  full;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;

  assign pld      = {req_payload, req_srcid, req_tgtid, req_qos, req_last};
  assign rptr_s   = rsync_q[SYNC_STAGES-1];
  assign wptr_nxt = {wptr_q[FIFO_DEPTH-2:0], ~wptr_q[FIFO_DEPTH-1]};

  // Full when the writer is exactly N codes ahead: its code is the bitwise
  // complement of the (synchronized) reader code.
  assign empty_w  = (wptr_q == rptr_s);
  assign full     = (wptr_q == ~rptr_s);

  // rst is folded in so the producer sees no ready while reset is held,
  // independent of any clock edge.
  assign req_ready = !rst && !full && !stall && !clear;
  assign wr_en     = req_valid && req_ready;
  assign wr_idx    = jidx(wptr_q);

  always_comb begin
    wptr_d      = wptr_q;
    rsync_d     = {rsync_q[SYNC_STAGES-2:0], rptr_async};
    full_zero_d = empty_w;
    mem_d       = mem_q;
    if (clear) begin
      // Pointers restart together with the reader; stored data is left alone.
      wptr_d  = '0;
      rsync_d = '0;
    end else if (wr_en) begin
      wptr_d         = wptr_nxt;
      mem_d[wr_idx]  = pld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rsync_q     <= '0;
      full_zero_q <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q      <= wptr_d;
      rsync_q     <= rsync_d;
      full_zero_q <= full_zero_d;
      mem_q       <= mem_d;
    end
  end

  assign wptr_async = wptr_q;
  assign full_zero  = full_zero_q;
  assign pld_sync   = mem_q[jidx(rptr_sync)];

endmodule

// File: doc/dti_pr_tniu_req_afifo_wr.md
Name: dti_pr_tniu_req_afifo_wr

Overview:
- Write-side (producer) endpoint of the DTI PR request async FIFO. It sits in the TNIU/far-side clock domain.
- It accepts request beats over a valid/ready handshake, stores them in a local register file, and publishes a Johnson-coded write pointer.
- The INIU top-side async FIFO master reads the entries. It returns its read pointer twice: as a raw async copy for synchronization, and as a live mux select for payload readout.
- It exposes stall, clear and full_zero hooks for the LP async bridge.

Parameters:
- DATA_WIDTH, 104, packed beat width = 90 payload + 6 srcid + 6 tgtid + 1 qos + 1 last.
- FIFO_DEPTH, 16, entry count; also the pointer width. Must be >= 2.
- SYNC_STAGES, 2, flop stages on the rptr_async synchronizer. Must be >= 2.

Ports:
- clk  in  1  single clock, write domain.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  beat valid.
- req_payload  in  90  beat data plus keep.
- req_last  in  1  last beat of packet.
- req_srcid  in  6  source TBU id.
- req_tgtid  in  6  target TBU id.
- req_qos  in  1  qos (tie 1 upstream).
- req_ready  out  1  beat accepted when req_valid and req_ready are both 1.
- stall  in  1  LP stall: block new writes.
- clear  in  1  LP clear: synchronous pointer reset.
- full_zero  out  1  all written entries consumed by reader.
- wptr_async  out  FIFO_DEPTH  Johnson write pointer, driven directly from flop.
- rptr_async  in  FIFO_DEPTH  reader Johnson pointer, asynchronous; synchronized here.
- rptr_sync  in  FIFO_DEPTH  reader Johnson pointer used only as readout mux select.
- pld_sync  out  DATA_WIDTH  mem entry selected by rptr_sync, combinational.

Behaviour:
- Packing: pld = {req_payload, req_srcid, req_tgtid, req_qos, req_last}. Bit 0 is last, bit 1 is qos, [7:2] is tgtid, [13:8] is srcid, [103:14] is payload.
- Johnson pointer, N = FIFO_DEPTH:
  - next = {p[N-2:0], ~p[N-1]}, giving 2N states, single-bit change per step.
  - Sequence from all-zeros (N=4): 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then 0000.
  - Entry index idx(p) = (p[N-1] ? N - popcount(p) : popcount(p)) mod N.
- rptr_s = output of the SYNC_STAGES-deep flop chain on rptr_async.
- empty_w = (wptr == rptr_s). full = (wptr == ~rptr_s).
- req_ready = !full && !stall && !clear. It is combinational and does not depend on req_valid.
- On a write (req_valid && req_ready): mem[idx(wptr)] <= pld and wptr <= next(wptr) in the same edge. The new wptr_async is visible the cycle after the accept.
- pld_sync = mem[idx(rptr_sync)], purely combinational.
- full_zero = empty_w, registered: it updates one cycle after wptr or rptr_s changes.
- clear, level-sampled each cycle:
  - wptr <= 0 and the sync chain <= 0; mem is untouched.
  - clear blocks any same-cycle write; clear has priority over valid.
  - full_zero reads 1 the cycle after clear deasserts, provided rptr_async = 0.
- stall only gates req_ready. In-flight state is kept, and the reader continues to drain.
- Reset (rst=1, asynchronous): wptr = 0, sync chain = 0, mem = 0, full_zero = 1, req_ready = 0 while rst is high.
  - A reset mid-packet drops the partial packet.
  - The reader is expected to be reset or cleared in step via LP.
- Wrap: the pointer passes through all 2N codes. Full is reached after exactly N unread writes, with no off-by-one.
- Throughput: one beat per cycle while not full.
- Backpressure release: after the reader advances, req_ready rises SYNC_STAGES to SYNC_STAGES+1 cycles later.
- req_valid may drop without acceptance; there is no stickiness requirement on the producer.

Test Plan:
- Reset, then 3 beats with payload 1, 2, 3 and rptr held at 0:
  - wptr goes 0001, 0011, 0111.
  - With rptr_sync = 0000/0001/0011, pld_sync[103:14] = 1/2/3.
  - full_zero = 0.
- Hold rptr_async = 0 and drive 16 back-to-back valids (FIFO_DEPTH = 16):
  - All 16 beats are accepted.
  - req_ready = 0 once wptr = all-ones-complement of 0 (0xFFFF), i.e. full.
  - A 17th beat is not accepted.
- From the full state, step rptr_async by one code:
  - req_ready returns after 2 to 3 cycles.
  - The next write lands in index 0, and wptr = 0xFFFE.
- Run 40 writes while the reader tracks 2 behind:
  - wptr wraps through 0000.
  - Data is read back in order with no loss.
  - full_zero = 1 after the reader catches up, with 1 cycle latency.
- Assert stall during a valid burst: req_ready = 0 and wptr frozen. Deassert stall: resume at the same index.
- Pulse clear with req_valid = 1 at wptr = 0x00FF:
  - No write occurs and wptr = 0.
  - The next accepted beat goes to mem[0].
- Assert rst asynchronously mid-burst: outputs reach reset values immediately, with no clock edge required.
